// File: rtl/router_input_stage.sv
// Per-port router input stage: 2-entry flit FIFO, routing-header decode with
// per-packet target hold, alternating lane select and protocol-error counting.
package router_axis_pkg;
   localparam int AXIS_TDATA_W = 40;
   localparam int AXIS_TID_W   = 4;
   localparam logic [AXIS_TID_W-1:0] ROUTING_HEADER = 4'hF;

   typedef struct packed {
      logic [AXIS_TDATA_W-1:0] TDATA;
      logic [AXIS_TID_W-1:0]   TID;
      logic                    TLAST;
   } axis_data_t;

   typedef struct packed {
      logic       TVALID;
      axis_data_t data;
   } axis_mosi_t;

   typedef struct packed {
      logic TREADY;
   } axis_miso_t;
endpackage

module router_input_stage
   import router_axis_pkg::*;
#(
   parameter int AXIS_DATA_WIDTH      = 40,
   parameter int CHANNEL_NUMBER       = 10,
   parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
   parameter int MAX_ROUTERS_X        = 4,
   parameter int MAX_ROUTERS_Y        = 4,
   parameter int MAX_ROUTERS_X_WIDTH  = $clog2(MAX_ROUTERS_X),
   parameter int MAX_ROUTERS_Y_WIDTH  = $clog2(MAX_ROUTERS_Y),
   parameter int ERR_CNT_WIDTH        = 8
)(
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  axis_mosi_t                      in_mosi_i,
   output axis_miso_t                      in_miso_o,
   output axis_mosi_t                      out_mosi_o,
   input  axis_miso_t                      out_miso_i,
   output logic [MAX_ROUTERS_X_WIDTH-1:0]  target_x_o,
   output logic [MAX_ROUTERS_Y_WIDTH-1:0]  target_y_o,
   output logic [CHANNEL_NUMBER_WIDTH-1:0] current_grant_o,
   output logic [ERR_CNT_WIDTH-1:0]        err_count_o
);

   typedef enum logic {IDLE, PACKET} state_t;

   function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   state_t state_q, state_d;

   logic [AXIS_DATA_WIDTH-1:0] mem_tdata [2];
   logic [AXIS_TID_W-1:0]      mem_tid   [2];
   logic                       mem_tlast [2];
   logic                       wr_ptr_q, rd_ptr_q;
   logic [1:0]                 count_q;

   logic [MAX_ROUTERS_X_WIDTH-1:0] hold_x_q;
   logic [MAX_ROUTERS_Y_WIDTH-1:0] hold_y_q;
   logic                           lane_q;
   logic [ERR_CNT_WIDTH-1:0]       err_q;

   logic [AXIS_DATA_WIDTH-1:0] head_tdata;
   logic [AXIS_TID_W-1:0]      head_tid;
   logic                       head_tlast, head_valid, head_hdr;
   logic [MAX_ROUTERS_X_WIDTH-1:0] head_x;
   logic [MAX_ROUTERS_Y_WIDTH-1:0] head_y;

   logic in_ready, out_ready, push, pop;
   logic out_valid, drop, show_head, hdr_latch, err_inc, lane_flip;

   assign head_tdata = mem_tdata[rd_ptr_q];
   assign head_tid   = mem_tid[rd_ptr_q];
   assign head_tlast = mem_tlast[rd_ptr_q];
   assign head_valid = (count_q != 2'd0);
   assign head_hdr   = (head_tid == ROUTING_HEADER);
   assign head_x     = head_tdata[MAX_ROUTERS_X_WIDTH-1:0];
   assign head_y     = head_tdata[MAX_ROUTERS_X_WIDTH +: MAX_ROUTERS_Y_WIDTH];

   // Ready is forced low while reset is held so nothing is accepted then.
   assign in_ready  = !rst_i && (count_q != 2'd2);
   assign out_ready = out_miso_i.TREADY;
   assign push      = in_mosi_i.TVALID && in_ready;
   assign pop       = (out_valid && out_ready) || drop;

   always_comb begin
      state_d   = state_q;
      out_valid = 1'b0;
      drop      = 1'b0;
      show_head = 1'b0;
      hdr_latch = 1'b0;
      err_inc   = 1'b0;
      lane_flip = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (head_valid) begin
               if (head_hdr) begin
                  out_valid = 1'b1;
                  show_head = 1'b1;
                  if (out_ready) begin
                     hdr_latch = 1'b1;
                     if (head_tlast) lane_flip = 1'b1;
                     else            state_d   = PACKET;
                  end
               end else begin
                  drop    = 1'b1;
                  err_inc = 1'b1;
               end
            end
         end
         PACKET: begin
            if (head_valid) begin
               out_valid = 1'b1;
               if (out_ready) begin
                  // A header inside a packet is passed through as data but flagged.
                  if (head_hdr) err_inc = 1'b1;
                  if (head_tlast) begin
                     lane_flip = 1'b1;
                     state_d   = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
         hold_x_q <= '0;
         hold_y_q <= '0;
         lane_q   <= 1'b0;
         err_q    <= '0;
      end else begin
         state_q <= state_d;
         if (push) wr_ptr_q <= ~wr_ptr_q;
         if (pop)  rd_ptr_q <= ~rd_ptr_q;
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
         if (hdr_latch) begin
            hold_x_q <= head_x;
            hold_y_q <= head_y;
         end
         if (lane_flip) lane_q <= ~lane_q;
         if (err_inc)   err_q  <= sat_inc(err_q);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_tdata[wr_ptr_q] <= in_mosi_i.data.TDATA;
         mem_tid[wr_ptr_q]   <= in_mosi_i.data.TID;
         mem_tlast[wr_ptr_q] <= in_mosi_i.data.TLAST;
      end
   end

   assign in_miso_o.TREADY = in_ready;
   assign out_mosi_o       = {out_valid, head_tdata, head_tid, head_tlast};
   assign target_x_o       = show_head ? head_x : hold_x_q;
   assign target_y_o       = show_head ? head_y : hold_y_q;
   assign current_grant_o  = {{(CHANNEL_NUMBER_WIDTH-1){1'b0}}, lane_q};
   assign err_count_o      = err_q;

endmodule

// File: tb/tb_router_input_stage.sv
// Directed scoreboard bench for router_input_stage.
module tb_router_input_stage;
   import router_axis_pkg::*;

   logic       clk = 1'b0;
   logic       rst_i;
   axis_mosi_t in_mosi, out_mosi;
   axis_miso_t in_miso, out_miso;
   logic [1:0] tx, ty;
   logic [3:0] grant;
   logic [7:0] err;

   int vectors = 0;
   int miscompares = 0;

   typedef struct packed {
      logic [39:0] tdata;
      logic [3:0]  tid;
      logic        tlast;
      logic [1:0]  x;
      logic [1:0]  y;
      logic [3:0]  grant;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   router_input_stage dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .in_mosi_i      (in_mosi),
      .in_miso_o      (in_miso),
      .out_mosi_o     (out_mosi),
      .out_miso_i     (out_miso),
      .target_x_o     (tx),
      .target_y_o     (ty),
      .current_grant_o(grant),
      .err_count_o    (err)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (!rst_i && out_mosi.TVALID && out_miso.TREADY) begin
         exp_t a, e;
         a = '{tdata: out_mosi.data.TDATA, tid: out_mosi.data.TID, tlast: out_mosi.data.TLAST,
               x: tx, y: ty, grant: grant};
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_flit: got %0h required none", a);
         end else begin
            e = exp_q.pop_front();
            check("flit", 64'(a), 64'(e));
         end
      end
   end

   task automatic send(input logic [39:0] d, input logic [3:0] id, input logic last,
                       input bit expect_out, input logic [1:0] ex, input logic [1:0] ey,
                       input logic [3:0] eg);
      bit ok;
      ok = 1'b0;
      in_mosi.TVALID     = 1'b1;
      in_mosi.data.TDATA = d;
      in_mosi.data.TID   = id;
      in_mosi.data.TLAST = last;
      for (int i = 0; i < 100; i++) begin
         ok = in_miso.TREADY;
         @(posedge clk); #1;
         if (ok) break;
      end
      if (!ok) check("send_timeout", 64'(0), 64'(1));
      else if (expect_out)
         exp_q.push_back('{tdata: d, tid: id, tlast: last, x: ex, y: ey, grant: eg});
   endtask

   task automatic idle(input int n);
      in_mosi.TVALID = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drain();
      in_mosi.TVALID = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk); #1;
      end
      check("drain_left", 64'(exp_q.size()), 64'(0));
      @(posedge clk); #1;
   endtask

   initial begin
      rst_i = 1'b1;
      in_mosi = '0;
      out_miso.TREADY = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tready", 64'(in_miso.TREADY), 64'(0));
      check("rst_tvalid", 64'(out_mosi.TVALID), 64'(0));
      check("rst_state", 64'({tx, ty, grant, err}), 64'(0));
      rst_i = 1'b0;
      #1;
      check("rel_tready", 64'(in_miso.TREADY), 64'(1));
      @(posedge clk); #1;

      // Two back-to-back packets on alternating lanes
      send(40'h5,   4'hF, 1'b0, 1, 2'd1, 2'd1, 4'd0);
      send(40'h100, 4'h0, 1'b1, 1, 2'd1, 2'd1, 4'd0);
      send(40'hB,   4'hF, 1'b0, 1, 2'd3, 2'd2, 4'd1);
      send(40'h200, 4'h0, 1'b0, 1, 2'd3, 2'd2, 4'd1);
      send(40'h201, 4'h0, 1'b1, 1, 2'd3, 2'd2, 4'd1);
      drain();
      check("grant_b2b", 64'(grant), 64'(0));

      // Header X=2,Y=3 plus three body flits
      send(40'hE, 4'hF, 1'b0, 1, 2'd2, 2'd3, 4'd0);
      check("latency_valid", 64'({out_mosi.TVALID, out_mosi.data.TDATA}), 64'({1'b1, 40'hE}));
      check("latency_target", 64'({tx, ty}), 64'({2'd2, 2'd3}));
      send(40'h111, 4'h0, 1'b0, 1, 2'd2, 2'd3, 4'd0);
      send(40'h222, 4'h0, 1'b0, 1, 2'd2, 2'd3, 4'd0);
      send(40'h333, 4'h0, 1'b1, 1, 2'd2, 2'd3, 4'd0);
      drain();
      check("grant_pktA", 64'(grant), 64'(1));

      // Backpressure with a full FIFO
      out_miso.TREADY = 1'b0;
      send(40'h4,   4'hF, 1'b0, 1, 2'd0, 2'd1, 4'd1);
      send(40'h400, 4'h0, 1'b0, 1, 2'd0, 2'd1, 4'd1);
      in_mosi.TVALID = 1'b0;
      check("bp_full_tready", 64'(in_miso.TREADY), 64'(0));
      for (int i = 0; i < 5; i++) begin
         check("bp_hold", 64'({out_mosi.TVALID, out_mosi.data.TDATA, tx, ty}),
               64'({1'b1, 40'h4, 2'd0, 2'd1}));
         @(posedge clk); #1;
      end
      out_miso.TREADY = 1'b1;
      send(40'h401, 4'h0, 1'b0, 1, 2'd0, 2'd1, 4'd1);
      send(40'h402, 4'h0, 1'b1, 1, 2'd0, 2'd1, 4'd1);
      drain();
      check("grant_bp", 64'(grant), 64'(0));

      // Stray body flit in IDLE, then a header inside a packet
      send(40'h77, 4'h0, 1'b0, 0, 2'd0, 2'd0, 4'd0);
      check("stray_no_valid", 64'(out_mosi.TVALID), 64'(0));
      idle(2);
      check("err_stray", 64'(err), 64'(1));
      send(40'h9,   4'hF, 1'b0, 1, 2'd1, 2'd2, 4'd0);
      send(40'h2,   4'hF, 1'b0, 1, 2'd1, 2'd2, 4'd0);
      send(40'h500, 4'h0, 1'b1, 1, 2'd1, 2'd2, 4'd0);
      drain();
      check("err_hdr_in_pkt", 64'(err), 64'(2));
      check("grant_hdr_pkt", 64'(grant), 64'(1));

      // Single-flit packet leaves the FSM in IDLE
      send(40'hF, 4'hF, 1'b1, 1, 2'd3, 2'd3, 4'd1);
      drain();
      check("grant_single", 64'(grant), 64'(0));
      send(40'h88, 4'h0, 1'b1, 0, 2'd0, 2'd0, 4'd0);
      idle(2);
      check("err_after_single", 64'({grant, err}), 64'({4'd0, 8'd3}));

      for (int i = 0; i < 300; i++)
         send(40'(i) + 40'h1000, 4'h0, 1'b0, 0, 2'd0, 2'd0, 4'd0);
      idle(2);
      check("err_saturate", 64'(err), 64'(255));

      // Reset asserted mid-packet
      send(40'h0, 4'hF, 1'b1, 1, 2'd0, 2'd0, 4'd0);
      drain();
      check("grant_pre_rst", 64'(grant), 64'(1));
      out_miso.TREADY = 1'b0;
      send(40'h6,   4'hF, 1'b0, 0, 2'd0, 2'd0, 4'd0);
      send(40'h600, 4'h0, 1'b0, 0, 2'd0, 2'd0, 4'd0);
      check("pre_rst_target", 64'({tx, ty}), 64'({2'd2, 2'd1}));
      rst_i = 1'b1;
      #1;
      check("mid_rst_valid_ready", 64'({out_mosi.TVALID, in_miso.TREADY}), 64'(0));
      check("mid_rst_regs", 64'({tx, ty, grant, err}), 64'(0));
      exp_q.delete();
      in_mosi.TVALID = 1'b0;
      out_miso.TREADY = 1'b1;
      @(posedge clk); #1;
      rst_i = 1'b0;
      #1;
      check("post_rst_tready", 64'(in_miso.TREADY), 64'(1));
      send(40'h5, 4'hF, 1'b1, 1, 2'd1, 2'd1, 4'd0);
      drain();
      check("grant_post_rst", 64'(grant), 64'(1));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
